// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the pipeline Memory stage
//   (CPU) and an external burst requester (loader / DMA / debug).
//   - By default the CPU owns the memory, with no added latency.
//   - The external port is granted 1..2^LEN_W word bursts, one beat per cycle.
//   - A starvation counter bounds how long the external side can wait while
//     the CPU keeps the memory busy.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_cpu_req/we/addr/wdata Memory stage access (load or store)
//   o_cpu_rdata             load data, passed straight through from i_mem_rd
//   o_cpu_stall             CPU access not serviced this cycle
//   i_ext_req/we/addr/len   burst request, held until o_ext_gnt; beats = len+1
//   i_ext_wdata             write beat data, consumed when o_ext_wready
//   o_ext_gnt               1-cycle pulse: request accepted, fields latched
//   o_ext_wready            write beat consumed this cycle
//   o_ext_rdata/o_ext_rvalid registered read beat data, one cycle after beat
//   o_ext_done              1-cycle pulse on the last burst beat
//   o_mem_a/wd/we, i_mem_rd datamem interface (combinational read)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_W      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [WIDTH-1:0]      i_cpu_wdata,
  output logic [WIDTH-1:0]      o_cpu_rdata,
  output logic                  o_cpu_stall,
  input  logic                  i_ext_req,
  input  logic                  i_ext_we,
  input  logic [ADDR_WIDTH-1:0] i_ext_addr,
  input  logic [LEN_W-1:0]      i_ext_len,
  input  logic [WIDTH-1:0]      i_ext_wdata,
  output logic                  o_ext_gnt,
  output logic                  o_ext_wready,
  output logic [WIDTH-1:0]      o_ext_rdata,
  output logic                  o_ext_rvalid,
  output logic                  o_ext_done,
  output logic [ADDR_WIDTH-1:0] o_mem_a,
  output logic [WIDTH-1:0]      o_mem_wd,
  output logic                  o_mem_we,
  input  logic [WIDTH-1:0]      i_mem_rd
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  typedef enum logic {S_CPU, S_EXT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SC_W-1:0]       r_starve_cnt;
  logic [LEN_W-1:0]      r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_burst_addr;
  logic                  r_burst_we;
  logic [WIDTH-1:0]      r_ext_rdata;
  logic                  r_ext_rvalid;
  logic                  w_accept;
  logic                  w_read_beat;

  // Load data is simply the memory read port; it is only meaningful to the
  // CPU when it is not stalled.
  assign o_cpu_rdata  = i_mem_rd;
  assign o_ext_rdata  = r_ext_rdata;
  assign o_ext_rvalid = r_ext_rvalid;
  assign w_read_beat  = (r_state == S_EXT) && !r_burst_we;

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    o_mem_a      = i_cpu_addr;
    o_mem_wd     = i_cpu_wdata;
    o_mem_we     = i_cpu_req & i_cpu_we;
    o_cpu_stall  = 1'b0;
    o_ext_gnt    = 1'b0;
    o_ext_wready = 1'b0;
    o_ext_done   = 1'b0;
    case (r_state)
      S_CPU: begin
        // CPU keeps priority until it has blocked the external side for
        // STARVE_MAX contended cycles; the CPU access in the grant cycle is
        // still serviced since the burst only starts next cycle.
        w_accept  = i_ext_req & (!i_cpu_req | (r_starve_cnt == STARVE_LIM));
        o_ext_gnt = w_accept;
        if (w_accept) w_state_nxt = S_EXT;
      end
      S_EXT: begin
        o_mem_a      = r_burst_addr;
        o_mem_wd     = i_ext_wdata;
        o_mem_we     = r_burst_we;
        o_ext_wready = r_burst_we;
        o_cpu_stall  = i_cpu_req;
        if (r_beat_cnt == '0) begin
          o_ext_done  = 1'b1;
          w_state_nxt = S_CPU;
        end
      end
      default: w_state_nxt = S_CPU;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_CPU;
      r_starve_cnt <= '0;
      r_beat_cnt   <= '0;
      r_burst_addr <= '0;
      r_burst_we   <= 1'b0;
      r_ext_rdata  <= '0;
      r_ext_rvalid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_CPU) begin
        if (w_accept) begin
          r_starve_cnt <= '0;
        end else if (i_ext_req && i_cpu_req && (r_starve_cnt != STARVE_LIM)) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end

      if (w_accept) begin
        r_burst_addr <= i_ext_addr;
        r_burst_we   <= i_ext_we;
        r_beat_cnt   <= i_ext_len;
      end else if (r_state == S_EXT) begin
        // Address wraps naturally at the top of the address space.
        r_burst_addr <= r_burst_addr + ADDR_WIDTH'(4);
        if (r_beat_cnt != '0) r_beat_cnt <= r_beat_cnt - 1'b1;
      end

      r_ext_rvalid <= w_read_beat;
      if (w_read_beat) r_ext_rdata <= i_mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr;
  logic [3:0]  ext_len;
  logic [31:0] ext_wdata;
  logic        ext_gnt, ext_wready, ext_rvalid, ext_done;
  logic [31:0] ext_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  dmem_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .LEN_W(4), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_addr(ext_addr),
    .i_ext_len(ext_len), .i_ext_wdata(ext_wdata), .o_ext_gnt(ext_gnt),
    .o_ext_wready(ext_wready), .o_ext_rdata(ext_rdata), .o_ext_rvalid(ext_rvalid),
    .o_ext_done(ext_done), .o_mem_a(mem_a), .o_mem_wd(mem_wd), .o_mem_we(mem_we),
    .i_mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small word memory standing in for datamem; backdoor port preloads it.
  logic [31:0] tmem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_val;
  always @(posedge clk) begin
    if (bd_we) tmem[bd_idx] <= bd_val;
    else if (mem_we) tmem[mem_a[9:2]] <= mem_wd;
  end
  assign mem_rd = tmem[mem_a[9:2]];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        er, ew;
    logic [31:0] ea;
    logic [3:0]  el;
    logic [31:0] ed;
    logic        e_stall, e_gnt;
    logic [31:0] e_ma;
    logic        e_mwe, e_wr, e_done, chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock and let the scoreboard consume any read beat.
  task automatic clk_step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (ext_rvalid) begin
      if (sb.size() == 0) chk("rvalid_unexpected", 64'(ext_rvalid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("ext_rdata", 64'(ext_rdata), 64'(e));
      end
    end
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_len = 0; ext_wdata = 0;
  endtask

  initial begin
    // CPU store/load, then starvation with a held CPU load and a 2-beat write
    vt[0]  = '{H,H,32'h10,32'hDEADBEEF, L,L,32'h0,4'd0,32'h0, L,L,32'h10,H,L,L, L,32'h0};
    vt[1]  = '{H,L,32'h10,32'h0,        L,L,32'h0,4'd0,32'h0, L,L,32'h10,L,L,L, H,32'hDEADBEEF};
    vt[2]  = '{H,L,32'h20,32'h0, H,H,32'h40,4'd1,32'h0, L,L,32'h20,L,L,L, L,32'h0};
    vt[3]  = vt[2];
    vt[4]  = vt[2];
    vt[5]  = vt[2];
    vt[6]  = '{H,L,32'h20,32'h0, H,H,32'h40,4'd1,32'h0, L,H,32'h20,L,L,L, L,32'h0};
    vt[7]  = '{H,L,32'h20,32'h0, H,H,32'h40,4'd1,32'hA5A50001, H,L,32'h40,H,H,L, L,32'h0};
    vt[8]  = '{H,L,32'h20,32'h0, H,H,32'h40,4'd1,32'hA5A50002, H,L,32'h44,H,H,H, L,32'h0};
    vt[9]  = '{H,L,32'h40,32'h0, L,L,32'h0,4'd0,32'h0, L,L,32'h40,L,L,L, H,32'hA5A50001};
    vt[10] = '{H,L,32'h44,32'h0, L,L,32'h0,4'd0,32'h0, L,L,32'h44,L,L,L, H,32'hA5A50002};

    idle();
    bd_we = 0; bd_idx = 0; bd_val = 0;
    rst_n = 0;
    // Preload memory while reset is held.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bd_we = 1;
      if (i < 8) begin bd_idx = 8'(64 + i); bd_val = 32'h1111_0000 + 32'(i); end
      else if (i == 8) begin bd_idx = 8'd255; bd_val = 32'h5555AAAA; end
      else begin bd_idx = 8'd0; bd_val = 32'h0BADF00D; end
    end
    @(negedge clk);
    bd_we = 0;
    chk("rst_gnt", 64'(ext_gnt), 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_rvalid", 64'(ext_rvalid), 64'd0);
    chk("rst_rdata", 64'(ext_rdata), 64'd0);
    chk("rst_done", 64'(ext_done), 64'd0);
    chk("rst_wready", 64'(ext_wready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    clk_step();

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      cpu_req = vt[i].cr; cpu_we = vt[i].cw; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
      ext_req = vt[i].er; ext_we = vt[i].ew; ext_addr = vt[i].ea; ext_len = vt[i].el;
      ext_wdata = vt[i].ed;
      #2;
      chk($sformatf("v%0d_stall", i), 64'(cpu_stall), 64'(vt[i].e_stall));
      chk($sformatf("v%0d_gnt", i), 64'(ext_gnt), 64'(vt[i].e_gnt));
      chk($sformatf("v%0d_mem_a", i), 64'(mem_a), 64'(vt[i].e_ma));
      chk($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'(vt[i].e_mwe));
      chk($sformatf("v%0d_wready", i), 64'(ext_wready), 64'(vt[i].e_wr));
      chk($sformatf("v%0d_done", i), 64'(ext_done), 64'(vt[i].e_done));
      if (vt[i].chk_rd) chk($sformatf("v%0d_cpu_rdata", i), 64'(cpu_rdata), 64'(vt[i].e_rd));
      clk_step();
    end

    // Ext read burst len=3 @0x100 with CPU idle
    idle();
    ext_req = 1; ext_addr = 32'h100; ext_len = 4'd3;
    #2;
    chk("rd_gnt", 64'(ext_gnt), 64'd1);
    for (int i = 0; i < 4; i++) sb.push_back(32'h1111_0000 + 32'(i));
    clk_step();
    ext_req = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("rd_mem_a%0d", i), 64'(mem_a), 64'(32'h100 + 32'(4 * i)));
      chk($sformatf("rd_mem_we%0d", i), 64'(mem_we), 64'd0);
      chk($sformatf("rd_done%0d", i), 64'(ext_done), 64'(i == 3));
      if (i == 0) chk("rd_rvalid_c1", 64'(ext_rvalid), 64'd0);
      clk_step();
    end
    cpu_req = 1; cpu_addr = 32'h10;
    #2;
    chk("rd_after_stall", 64'(cpu_stall), 64'd0);
    chk("rd_after_cpu_rdata", 64'(cpu_rdata), 64'(32'hDEADBEEF));
    clk_step();
    idle();
    chk("rd_rvalid_c6", 64'(ext_rvalid), 64'd0);
    chk("rd_sb_empty", 64'(sb.size()), 64'd0);

    // Address wrap
    ext_req = 1; ext_addr = 32'hFFFFFFFC; ext_len = 4'd1;
    #2;
    chk("wrap_gnt", 64'(ext_gnt), 64'd1);
    sb.push_back(32'h5555AAAA);
    sb.push_back(32'h0BADF00D);
    clk_step();
    ext_req = 0;
    #2;
    chk("wrap_mem_a0", 64'(mem_a), 64'(32'hFFFFFFFC));
    clk_step();
    #2;
    chk("wrap_mem_a1", 64'(mem_a), 64'(32'h0));
    chk("wrap_done", 64'(ext_done), 64'd1);
    clk_step();
    chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // Back-to-back single-beat bursts, ext_req held through ext_done
    ext_req = 1; ext_addr = 32'h10; ext_len = 4'd0;
    #2;
    chk("b2b_gnt1", 64'(ext_gnt), 64'd1);
    sb.push_back(32'hDEADBEEF);
    clk_step();
    #2;
    chk("b2b_done1", 64'(ext_done), 64'd1);
    chk("b2b_nogntext", 64'(ext_gnt), 64'd0);
    clk_step();
    #2;
    chk("b2b_gnt2", 64'(ext_gnt), 64'd1);
    sb.push_back(32'hDEADBEEF);
    clk_step();
    ext_req = 0;
    #2;
    chk("b2b_done2", 64'(ext_done), 64'd1);
    clk_step();
    chk("b2b_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of an 8-beat read burst
    ext_req = 1; ext_addr = 32'h100; ext_len = 4'd7;
    #2;
    chk("rst_burst_gnt", 64'(ext_gnt), 64'd1);
    for (int i = 0; i < 8; i++) sb.push_back(32'h1111_0000 + 32'(i));
    clk_step();
    ext_req = 0;
    clk_step();
    clk_step();
    #1;
    chk("rst_burst_beat2", 64'(mem_a), 64'(32'h108));
    cpu_req = 1; cpu_addr = 32'h10;
    rst_n = 0;
    #1;
    sb.delete();
    chk("mid_rst_gnt", 64'(ext_gnt), 64'd0);
    chk("mid_rst_done", 64'(ext_done), 64'd0);
    chk("mid_rst_stall", 64'(cpu_stall), 64'd0);
    chk("mid_rst_rvalid", 64'(ext_rvalid), 64'd0);
    chk("mid_rst_rdata", 64'(ext_rdata), 64'd0);
    chk("mid_rst_mem_a", 64'(mem_a), 64'(32'h10));
    clk_step();
    chk("mid_rst_done2", 64'(ext_done), 64'd0);
    rst_n = 1;
    cpu_we = 1; cpu_addr = 32'h18; cpu_wdata = 32'hCAFEF00D;
    #2;
    chk("post_rst_stall", 64'(cpu_stall), 64'd0);
    chk("post_rst_mem_we", 64'(mem_we), 64'd1);
    chk("post_rst_done", 64'(ext_done), 64'd0);
    clk_step();
    cpu_we = 0;
    #2;
    chk("post_rst_load", 64'(cpu_rdata), 64'(32'hCAFEF00D));
    chk("post_rst_stall2", 64'(cpu_stall), 64'd0);
    clk_step();
    chk("post_rst_rvalid", 64'(ext_rvalid), 64'd0);
    idle();
    clk_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
